// File: rtl/csr_issue_sequencer.sv
// CSR issue sequencer: releases one CSR op at a time to execute once it is the ROB head, and holds off the next op until the previous one commits.
// Optional build macro CSR_SEQ_STALL_COUNTER_EN adds a saturating seq_stall_cycles counter.
`timescale 1ns/1ps

package csr_issue_sequencer_pkg;
  localparam int unsigned PACK_ROB_ID_W = 8;

  typedef struct packed {
    logic                     valid;
    logic                     has_exception;
    logic [PACK_ROB_ID_W-1:0] rob_id;
    logic [11:0]              csr_addr;
    logic [2:0]               csr_op;
    logic [31:0]              rs1_data;
  } issue_execute_pack_t;

  typedef struct packed {
    logic enable;
    logic flush;
  } commit_feedback_pack_t;
endpackage

module csr_issue_sequencer
  import csr_issue_sequencer_pkg::*;
#(
  parameter int unsigned ROB_ID_WIDTH    = 6,
  parameter int unsigned STALL_CNT_WIDTH = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  issue_execute_pack_t         issue_csr_fifo_data_out,
  input  logic                        issue_csr_fifo_data_out_valid,
  output logic                        issue_csr_fifo_pop,
  output issue_execute_pack_t         seq_csr_data_out,
  output logic                        seq_csr_data_out_valid,
  input  logic                        seq_csr_pop,
  input  logic [ROB_ID_WIDTH-1:0]     rob_head_id,
  input  logic                        rob_head_valid,
  input  logic [ROB_ID_WIDTH-1:0]     commit_rob_id,
  input  logic                        commit_rob_valid,
  input  commit_feedback_pack_t       commit_feedback_pack,
`ifdef CSR_SEQ_STALL_COUNTER_EN
  output logic [STALL_CNT_WIDTH-1:0]  seq_stall_cycles,
`endif
  output logic                        seq_busy
);

  if (ROB_ID_WIDTH == 0 || ROB_ID_WIDTH > PACK_ROB_ID_W || STALL_CNT_WIDTH == 0) begin : g_bad_cfg
    $error("csr_issue_sequencer: ROB_ID_WIDTH must fit the pack rob_id field");
  end

  typedef enum logic [1:0] {
    IDLE,
    WAIT_HEAD,
    SEND,
    WAIT_COMMIT
  } state_e;

  state_e                  state_q, state_d;
  issue_execute_pack_t     held_q, held_d;
  logic                    flush;
  logic [ROB_ID_WIDTH-1:0] held_rob_id;

  assign flush       = commit_feedback_pack.enable && commit_feedback_pack.flush;
  assign held_rob_id = held_q.rob_id[ROB_ID_WIDTH-1:0];

  always_comb begin
    state_d                = state_q;
    held_d                 = held_q;
    issue_csr_fifo_pop     = 1'b0;
    seq_csr_data_out_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        // Reset also blocks the pop so nothing leaves the FIFO while reset is held.
        if (issue_csr_fifo_data_out_valid && !flush && !rst) begin
          issue_csr_fifo_pop = 1'b1;
          held_d             = issue_csr_fifo_data_out;
          state_d            = WAIT_HEAD;
        end
      end
      WAIT_HEAD: begin
        if (rob_head_valid && (rob_head_id == held_rob_id)) begin
          state_d = SEND;
        end
      end
      SEND: begin
        seq_csr_data_out_valid = !flush && !rst;
        if (seq_csr_pop) begin
          state_d = WAIT_COMMIT;
        end
      end
      WAIT_COMMIT: begin
        if (commit_rob_valid && (commit_rob_id == held_rob_id)) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Flush overrides any transition above, including a coincident consume.
    if (flush) begin
      state_d = IDLE;
      held_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      held_q  <= '0;
    end else begin
      state_q <= state_d;
      held_q  <= held_d;
    end
  end

  assign seq_csr_data_out = held_q;
  assign seq_busy         = (state_q != IDLE);

`ifdef CSR_SEQ_STALL_COUNTER_EN
  logic [STALL_CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (((state_q == WAIT_HEAD) || (state_q == WAIT_COMMIT)) && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign seq_stall_cycles = stall_cnt_q;
`endif

endmodule

// File: tb/tb_csr_issue_sequencer.sv
// Randomized scoreboard bench for csr_issue_sequencer; a per-cycle op-lifecycle model queues expectations, a negedge monitor checks them.
// Define CSR_SEQ_STALL_COUNTER_EN for both files to also check seq_stall_cycles.
`timescale 1ns/1ps

module tb_csr_issue_sequencer;
  import csr_issue_sequencer_pkg::*;

  localparam int unsigned RW = 6;
  localparam int unsigned SW = 32;

  logic                  clk = 1'b0;
  logic                  rst;
  issue_execute_pack_t   fifo_data;
  logic                  fifo_valid;
  logic                  fifo_pop;
  issue_execute_pack_t   out_data;
  logic                  out_valid;
  logic                  seq_pop;
  logic [RW-1:0]         head_id;
  logic                  head_valid;
  logic [RW-1:0]         commit_id;
  logic                  commit_valid;
  commit_feedback_pack_t fb;
  logic                  busy;
`ifdef CSR_SEQ_STALL_COUNTER_EN
  logic [SW-1:0]         stall_cycles;
`endif

  always #5 clk = ~clk;

  csr_issue_sequencer #(
    .ROB_ID_WIDTH    (RW),
    .STALL_CNT_WIDTH (SW)
  ) dut (
    .clk                           (clk),
    .rst                           (rst),
    .issue_csr_fifo_data_out       (fifo_data),
    .issue_csr_fifo_data_out_valid (fifo_valid),
    .issue_csr_fifo_pop            (fifo_pop),
    .seq_csr_data_out              (out_data),
    .seq_csr_data_out_valid        (out_valid),
    .seq_csr_pop                   (seq_pop),
    .rob_head_id                   (head_id),
    .rob_head_valid                (head_valid),
    .commit_rob_id                 (commit_id),
    .commit_rob_valid              (commit_valid),
    .commit_feedback_pack          (fb),
`ifdef CSR_SEQ_STALL_COUNTER_EN
    .seq_stall_cycles              (stall_cycles),
`endif
    .seq_busy                      (busy)
  );

  typedef struct {
    logic                pop;
    logic                valid;
    logic                busy;
    issue_execute_pack_t data;
    logic [SW-1:0]       stall;
  } exp_t;

  exp_t                exp_q[$];
  issue_execute_pack_t fifo_q[$];

  int unsigned total = 0;
  int unsigned bad   = 0;
  bit          armed = 1'b0;
  bit          force_wrap = 1'b0;

  // Reference model of the single outstanding op's lifecycle.
  bit                  have     = 1'b0;
  bit                  released = 1'b0;
  bit                  taken    = 1'b0;
  issue_execute_pack_t held     = '0;
  logic [SW-1:0]       stall_m  = '0;

  function automatic void check(string nm, logic [63:0] act, logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, req, $time);
    end
  endfunction

  function automatic bit pct(int unsigned p);
    return $urandom_range(0, 99) < p;
  endfunction

  function automatic issue_execute_pack_t new_op();
    issue_execute_pack_t op;
    int unsigned         sel;
    op.valid         = 1'($urandom);
    op.has_exception = 1'($urandom);
    op.csr_addr      = 12'($urandom);
    op.csr_op        = 3'($urandom);
    op.rs1_data      = $urandom;
    sel = $urandom_range(0, 3);
    if (force_wrap)    op.rob_id = {2'($urandom), 6'h3F};
    else if (sel == 0) op.rob_id = 8'h3F;
    else if (sel == 1) op.rob_id = 8'h00;
    else               op.rob_id = 8'($urandom);
    return op;
  endfunction

  function automatic void present_fifo();
    fifo_valid = (fifo_q.size() > 0);
    fifo_data  = (fifo_q.size() > 0) ? fifo_q[0] : issue_execute_pack_t'({$urandom, $urandom});
  endfunction

  function automatic void model_step();
    bit   fl;
    bit   in_wait;
    exp_t e;
    fl      = fb.enable && fb.flush;
    in_wait = have && (!released || taken);
    e.busy  = have;
    e.pop   = !have && (fifo_q.size() > 0) && !fl && !rst;
    e.valid = have && released && !taken && !fl && !rst;
    e.data  = held;
    e.stall = stall_m;
    exp_q.push_back(e);
    armed = 1'b1;

    if (rst)                             stall_m = '0;
    else if (in_wait && stall_m != '1)   stall_m = stall_m + 1;

    if (rst || fl) begin
      have = 1'b0; released = 1'b0; taken = 1'b0; held = '0;
    end else if (e.pop) begin
      held = fifo_q.pop_front();
      have = 1'b1; released = 1'b0; taken = 1'b0;
    end else if (have) begin
      if (!released) begin
        if (head_valid && head_id == held.rob_id[RW-1:0]) released = 1'b1;
      end else if (!taken) begin
        if (seq_pop) taken = 1'b1;
      end else if (commit_valid && commit_id == held.rob_id[RW-1:0]) begin
        have = 1'b0;
      end
    end
  endfunction

  task automatic run_cycle(input int unsigned pf, input int unsigned ph, input int unsigned pc,
                           input int unsigned pp, input int unsigned pr, input int unsigned pfill);
    @(posedge clk);
    #1;
    if (fifo_q.size() < 3 && pct(pfill)) fifo_q.push_back(new_op());
    present_fifo();
    rst       = pct(pr);
    fb.flush  = 1'($urandom);
    fb.enable = fb.flush ? pct(2 * pf) : 1'($urandom);
    head_valid = pct(85);
    head_id    = (have && pct(ph)) ? held.rob_id[RW-1:0] : RW'($urandom);
    commit_valid = pct(75);
    if (have && pct(pc)) commit_id = held.rob_id[RW-1:0];
    else if (force_wrap) commit_id = '0;
    else                 commit_id = RW'($urandom);
    seq_pop = pct(pp);
    #1;
    model_step();
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("pop",       64'(fifo_pop),  64'(e.pop));
        check("out_valid", 64'(out_valid), 64'(e.valid));
        check("busy",      64'(busy),      64'(e.busy));
        check("out_data",  64'(out_data),  64'(e.data));
`ifdef CSR_SEQ_STALL_COUNTER_EN
        check("stall_cycles", 64'(stall_cycles), 64'(e.stall));
`endif
      end else if (armed) begin
        total++;
        bad++;
        $display("FAIL expectation_queue actual=empty required=entry at %0t", $time);
      end
    end
  end

  initial begin : driver
    rst          = 1'b1;
    fb           = '0;
    seq_pop      = 1'b0;
    head_id      = '0;
    head_valid   = 1'b0;
    commit_id    = '0;
    commit_valid = 1'b0;
    fifo_q.push_back(new_op());
    fifo_q.push_back(new_op());
    present_fifo();

    // Reset held with the FIFO valid: nothing may pop until reset drops.
    repeat (2)   run_cycle(0, 0, 0, 0, 100, 0);
    repeat (250) run_cycle(0, 60, 60, 70, 0, 70);
    repeat (300) run_cycle(5, 8, 30, 50, 0, 60);
    force_wrap = 1'b1;
    repeat (200) run_cycle(2, 50, 15, 60, 0, 70);
    force_wrap = 1'b0;
    repeat (300) run_cycle(6, 40, 40, 50, 2, 50);

    @(negedge clk);
    #1;
    check("drain", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
